// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - CPU bus address map constants and OAM DMA state encoding
package nes_bus_pkg;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam logic [15:0] PPU_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE,
        DONE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - $4014 sprite DMA engine copying one CPU page to PPU OAMDATA
// OAM_DMA_ALIGN_EN: adds the odd-cycle ALIGN step before the first read
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_REG,
    parameter logic [15:0] OAM_DATA_ADDR = PPU_OAMDATA,
    parameter int          XFER_LEN      = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] CPU_ADDR,
    input  logic        CPU_RW_n,
    input  logic [7:0]  CPU_DATA_OUT,
    input  logic [7:0]  DMA_DATA_IN,
    output logic        DMA_HALT,
    output logic        DMA_BUS_OWN,
    output logic [15:0] DMA_ADDR,
    output logic        DMA_RW_n,
    output logic [7:0]  DMA_DATA_OUT,
    output logic        DMA_DONE
);

    localparam logic [8:0] LEN = 9'(XFER_LEN);

    dma_state_t  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [8:0]  count_q, count_d;
    logic [7:0]  latch_q, latch_d;

    logic        halt_q, halt_d;
    logic        own_q, own_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_n_q, rw_n_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;

`ifdef OAM_DMA_ALIGN_EN
    logic parity_q;

    always_ff @(posedge CLK) begin
        if (RESET) parity_q <= 1'b0;
        else       parity_q <= ~parity_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        count_d = count_q;
        latch_d = latch_q;
        case (state_q)
            IDLE: begin
                if (!CPU_RW_n && CPU_ADDR == DMA_REG_ADDR) begin
                    page_d  = CPU_DATA_OUT;
                    state_d = HALT;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_d = parity_q ? ALIGN : READ;
`else
                state_d = READ;
`endif
            end
            ALIGN: state_d = READ;
            READ: begin
                latch_d = DMA_DATA_IN;
                state_d = WRITE;
            end
            WRITE: begin
                count_d = count_q + 9'd1;
                state_d = (count_d == LEN) ? DONE : READ;
            end
            DONE: begin
                count_d = 9'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up with it.
    always_comb begin
        halt_d = (state_d == HALT) || (state_d == ALIGN) || (state_d == READ) || (state_d == WRITE);
        own_d  = (state_d == READ) || (state_d == WRITE);
        rw_n_d = (state_d != WRITE);
        done_d = (state_d == DONE);
        addr_d = 16'h0000;
        data_d = 8'h00;
        if (state_d == READ) begin
            addr_d = {page_d, count_d[7:0]};
        end else if (state_d == WRITE) begin
            addr_d = OAM_DATA_ADDR;
            data_d = latch_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            count_q <= 9'd0;
            latch_q <= 8'h00;
            halt_q  <= 1'b0;
            own_q   <= 1'b0;
            addr_q  <= 16'h0000;
            rw_n_q  <= 1'b1;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            count_q <= count_d;
            latch_q <= latch_d;
            halt_q  <= halt_d;
            own_q   <= own_d;
            addr_q  <= addr_d;
            rw_n_q  <= rw_n_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign DMA_HALT     = halt_q;
    assign DMA_BUS_OWN  = own_q;
    assign DMA_ADDR     = addr_q;
    assign DMA_RW_n     = rw_n_q;
    assign DMA_DATA_OUT = data_q;
    assign DMA_DONE     = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard bench for oam_dma with a transaction-level reference model
module tb_oam_dma;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] CPU_ADDR;
    logic        CPU_RW_n;
    logic [7:0]  CPU_DATA_OUT;
    logic [7:0]  DMA_DATA_IN;
    logic        DMA_HALT;
    logic        DMA_BUS_OWN;
    logic [15:0] DMA_ADDR;
    logic        DMA_RW_n;
    logic [7:0]  DMA_DATA_OUT;
    logic        DMA_DONE;

    oam_dma dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CPU_ADDR     (CPU_ADDR),
        .CPU_RW_n     (CPU_RW_n),
        .CPU_DATA_OUT (CPU_DATA_OUT),
        .DMA_DATA_IN  (DMA_DATA_IN),
        .DMA_HALT     (DMA_HALT),
        .DMA_BUS_OWN  (DMA_BUS_OWN),
        .DMA_ADDR     (DMA_ADDR),
        .DMA_RW_n     (DMA_RW_n),
        .DMA_DATA_OUT (DMA_DATA_OUT),
        .DMA_DONE     (DMA_DONE)
    );

    always #5 CLK = ~CLK;

    // Memory model: each byte is the low address byte xor a per-transfer key.
    logic [7:0] key = 8'h00;
    assign DMA_DATA_IN = DMA_ADDR[7:0] ^ key;

    typedef struct {
        logic [15:0] addr;
        logic        rw_n;
        logic [7:0]  data;
    } bus_t;

    bus_t exp_q[$];
    int   align_q[$];

    int errors = 0;
    int checks = 0;

    // Parity model: number of clock edges since reset, modulo two.
    bit par_m = 1'b0;
    always @(posedge CLK) par_m <= RESET ? 1'b0 : ~par_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    int  halt_cnt = 0;
    int  pre_own = 0;
    bit  seen_own = 1'b0;
    int  wr_seen = 0;
    int  done_seen = 0;

    always @(negedge CLK) begin
        bus_t e;
        int   a;
        if (RESET) begin
            halt_cnt = 0;
            pre_own  = 0;
            seen_own = 1'b0;
        end else begin
            if (DMA_HALT) begin
                halt_cnt++;
                if (!DMA_BUS_OWN && !seen_own) pre_own++;
            end
            if (DMA_BUS_OWN) begin
                seen_own = 1'b1;
                check("own_implies_halt", 32'(DMA_HALT), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_bus_cycle", {DMA_ADDR, 15'd0, DMA_RW_n}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_addr", 32'(DMA_ADDR), 32'(e.addr));
                    check("bus_rw_n", 32'(DMA_RW_n), 32'(e.rw_n));
                    if (!e.rw_n) begin
                        check("bus_wdata", 32'(DMA_DATA_OUT), 32'(e.data));
                        wr_seen++;
                    end
                end
            end
            if (DMA_DONE) begin
                if (align_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    a = align_q.pop_front();
                    check("halted_cycles", 32'(halt_cnt), 32'(1 + a + 512));
                    check("first_read_delay", 32'(pre_own), 32'(1 + a));
                    check("done_bus_released", {31'd0, DMA_BUS_OWN}, 32'd0);
                end
                halt_cnt = 0;
                pre_own  = 0;
                seen_own = 1'b0;
                done_seen++;
            end
        end
    end

    task automatic idle_bus();
        CPU_ADDR     = 16'h0000;
        CPU_RW_n     = 1'b1;
        CPU_DATA_OUT = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_halt"}, 32'(DMA_HALT), 32'd0);
        check({tag, "_own"},  32'(DMA_BUS_OWN), 32'd0);
        check({tag, "_addr"}, 32'(DMA_ADDR), 32'd0);
        check({tag, "_rw_n"}, 32'(DMA_RW_n), 32'd1);
        check({tag, "_data"}, 32'(DMA_DATA_OUT), 32'd0);
        check({tag, "_done"}, 32'(DMA_DONE), 32'd0);
    endtask

    // hp: required parity in the HALT cycle (0/1), or 2 for any.
    task automatic start_dma(input logic [7:0] page, input int hp);
        int a;
        @(negedge CLK);
        if (hp != 2) begin
            for (int i = 0; i < 4 && (~par_m) != hp[0]; i++) @(negedge CLK);
        end
`ifdef OAM_DMA_ALIGN_EN
        a = (~par_m) ? 1 : 0;
`else
        a = 0;
`endif
        align_q.push_back(a);
        for (int i = 0; i < 256; i++) begin
            bus_t r, w;
            r.addr = {page, 8'(i)};
            r.rw_n = 1'b1;
            r.data = 8'h00;
            w.addr = 16'h2004;
            w.rw_n = 1'b0;
            w.data = 8'(i) ^ key;
            exp_q.push_back(r);
            exp_q.push_back(w);
        end
        CPU_ADDR     = 16'h4014;
        CPU_RW_n     = 1'b0;
        CPU_DATA_OUT = page;
        @(negedge CLK);
        idle_bus();
        check("halt_at_t1", 32'(DMA_HALT), 32'd1);
        check("no_own_at_t1", 32'(DMA_BUS_OWN), 32'd0);
    endtask

    task automatic wait_done(input bit hammer);
        int d0 = done_seen;
        int n = 0;
        while (done_seen == d0 && n < 1200) begin
            @(negedge CLK);
            #1;
            n++;
            if (done_seen == d0 && hammer) begin
                CPU_RW_n     = 1'($urandom);
                CPU_ADDR     = ($urandom_range(0, 1) == 1) ? 16'h4014 : 16'($urandom);
                CPU_DATA_OUT = 8'($urandom);
            end
        end
        idle_bus();
        check("done_before_timeout", 32'(done_seen - d0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w0;
        RESET = 1'b1;
        idle_bus();
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RESET = 1'b0;

        // Even parity, identity data
        key = 8'h00;
        start_dma(8'h02, 0);
        wait_done(1'b0);

        // Odd parity
        key = 8'($urandom);
        start_dma(8'h02, 1);
        wait_done(1'b0);

        // Top page
        key = 8'($urandom);
        start_dma(8'hFF, 2);
        wait_done(1'b0);

        // Reset during the write of byte 100
        key = 8'($urandom);
        w0 = wr_seen;
        start_dma(8'h40, 2);
        for (int i = 0; i < 1200 && (wr_seen - w0) != 101; i++) begin
            @(negedge CLK);
            #1;
        end
        check("reached_byte_100", 32'(wr_seen - w0), 32'd101);
        RESET = 1'b1;
        exp_q.delete();
        align_q.delete();
        @(negedge CLK);
        #1;
        check_reset_outputs("mid_reset");
        RESET = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("post_reset_idle_halt", 32'(DMA_HALT), 32'd0);
            check("post_reset_no_done", 32'(DMA_DONE), 32'd0);
        end
        start_dma(8'h41, 2);
        wait_done(1'b0);

        // Near-miss accesses must not trigger
        for (int p = 0; p < 3; p++) begin
            @(negedge CLK);
            CPU_ADDR     = (p == 0) ? 16'h4015 : (p == 1) ? 16'h2004 : 16'h4014;
            CPU_RW_n     = (p == 2);
            CPU_DATA_OUT = 8'h07;
            repeat (4) begin
                @(negedge CLK);
                check_reset_outputs("no_trigger");
            end
        end
        idle_bus();

        // Trigger coincident with reset is discarded
        @(negedge CLK);
        RESET        = 1'b1;
        CPU_ADDR     = 16'h4014;
        CPU_RW_n     = 1'b0;
        CPU_DATA_OUT = 8'h05;
        @(negedge CLK);
        RESET = 1'b0;
        idle_bus();
        repeat (2) begin
            @(negedge CLK);
            check_reset_outputs("reset_trigger");
        end

        // Randomized transfers with CPU bus noise during and between them
        for (int t = 0; t < 6; t++) begin
            int gap = $urandom_range(0, 7);
            for (int g = 0; g < gap; g++) begin
                @(negedge CLK);
                CPU_ADDR     = 16'($urandom);
                CPU_RW_n     = 1'($urandom);
                CPU_DATA_OUT = 8'($urandom);
                if (CPU_ADDR == 16'h4014) CPU_RW_n = 1'b1;
            end
            @(negedge CLK);
            idle_bus();
            check("idle_between", 32'(DMA_HALT), 32'd0);
            key = 8'($urandom);
            start_dma(8'($urandom), 2);
            wait_done(1'b1);
        end

        repeat (3) @(negedge CLK);
        check("final_align_queue", 32'(align_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
CPU-bus DMA engine for the $4014 OAM DMA register. It sits on the CPU bus between the 2A03 core and the PPU register port. A CPU write of page P to $4014 halts the CPU, then the engine copies P*256..P*256+255 to the PPU OAMDATA port ($2004) as alternating read/write bus cycles. The top-level bus mux selects this block's address, RW_n and data whenever it owns the bus; CPU_ENABLE is gated by DMA_HALT.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
OAM_DATA_ADDR, 16'h2004, destination address for every write cycle.
XFER_LEN, 256, bytes per transfer (1..256).

Ports:
CLK  in  1  CPU clock; every state step is one CPU cycle.
RESET  in  1  synchronous, active-high.
CPU_ADDR  in  16  CPU core address output.
CPU_RW_n  in  1  CPU core read/write; 0 = write.
CPU_DATA_OUT  in  8  CPU core write data.
DMA_DATA_IN  in  8  CPU data bus read value, valid by the end of a DMA read cycle.
DMA_HALT  out  1  1 = CPU stalled; top level drives CPU ENABLE low.
DMA_BUS_OWN  out  1  1 = bus mux takes DMA_ADDR, DMA_RW_n and DMA_DATA_OUT.
DMA_ADDR  out  16  DMA bus address.
DMA_RW_n  out  1  DMA read/write; 0 = write.
DMA_DATA_OUT  out  8  byte driven during write cycles.
DMA_DONE  out  1  one-cycle pulse in the cycle after the last write.

Behaviour:
- Reset values: state IDLE; DMA_HALT=0, DMA_BUS_OWN=0, DMA_ADDR=0, DMA_RW_n=1, DMA_DATA_OUT=0, DMA_DONE=0; page=0, count=0, data latch=0, parity=0.
- parity: 1-bit flag that toggles every CLK edge from reset, independent of state.
- Trigger: in IDLE, sample CPU_RW_n==0 && CPU_ADDR==DMA_REG_ADDR at the edge. Latch page<=CPU_DATA_OUT and go to HALT. Triggers in any other state are ignored.
- States:
  - IDLE: no outputs asserted except DMA_RW_n=1.
  - HALT: DMA_HALT=1, DMA_BUS_OWN=0; one dummy cycle. Next state is ALIGN if parity==1 in this cycle, else READ.
  - ALIGN: DMA_HALT=1, DMA_BUS_OWN=0; one cycle, then READ.
  - READ: DMA_HALT=1, DMA_BUS_OWN=1, DMA_RW_n=1, DMA_ADDR={page,count[7:0]}. At the closing edge, latch<=DMA_DATA_IN, then go to WRITE.
  - WRITE: DMA_BUS_OWN=1, DMA_RW_n=0, DMA_ADDR=OAM_DATA_ADDR, DMA_DATA_OUT=latch. At the closing edge, count<=count+1. If the new count==XFER_LEN go to DONE, else READ.
  - DONE: DMA_HALT=0, DMA_BUS_OWN=0, DMA_DONE=1 for one cycle; count<=0; then IDLE. The CPU resumes in this cycle.
- All outputs are registered as functions of state; no combinational path from inputs to outputs.
- Latency, counting the trigger edge as t0: HALT at t1; first READ at t2, or t3 when aligned. Total halted cycles = 1 + align + 2*XFER_LEN = 513 or 514 for the default.
- Width rules:
  - count is 9 bits; only count[7:0] feeds the address.
  - The address low byte wraps within the page ($xxFF reads are followed by end of transfer, never a carry into page+1).
  - page $FF is legal and reads $FF00-$FFFF.
- Page $40-$41 are read as-is; there is no register side-effect filtering.
- RESET in any state returns to IDLE with reset values in the next cycle: the bus is released, no DONE pulse, and the partial OAM copy is not retried.
- A $4014 write coincident with RESET is discarded.

Optional Feature:
OAM_DMA_ALIGN_EN.
- Defined: the HALT→ALIGN branch on odd parity is present (513/514 cycles, hardware-accurate).
- Undefined: ALIGN is unreachable, HALT always goes to READ, the transfer is always exactly 1+2*XFER_LEN cycles, and the parity flag is optimised away.

Decomposition:
- Shared package nes_bus_pkg:
  - address constants (OAM_DMA_REG=16'h4014, PPU_OAMDATA=16'h2004)
  - dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE, DONE}
  - the DMA_REG_ADDR and OAM_DATA_ADDR parameter defaults take their values from this package.
- Single module; no sub-module is warranted. The counter and FSM are small and tightly coupled.

Test Plan:
1. Write $02 to $4014 at even parity with DMA_DATA_IN = low byte of DMA_ADDR.
   Expect: DMA_HALT high for 513 cycles; reads $0200..$02FF; 256 writes to $2004 carrying $00..$FF in order; DMA_DONE pulses once.
2. Same trigger at odd parity with OAM_DMA_ALIGN_EN defined.
   Expect: one ALIGN cycle, first READ at t3, 514 halted cycles. With the macro undefined, expect 513.
3. Page $FF.
   Expect: last read at $FFFF, then DONE, with no access to $0000.
4. Assert RESET during WRITE of byte 100.
   Expect: next cycle IDLE, DMA_HALT=0, DMA_BUS_OWN=0, DMA_RW_n=1, no DMA_DONE. A later $4014 write restarts from count 0.
5. Writes to $4015 and $2004, and a read of $4014.
   Expect: no trigger, and all outputs stay at reset values.
